// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite encodings, CPU access sizes and the data-memory master state type.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } dmem_state_e;

    // Size encoding 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit data bus: store strobes/replication and
// load extraction with sign or zero extension.
module lsu_lane_align
    import axi_lite_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sign_ext_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0]        ld_shift;
    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    // Bring the addressed lane down to bit 0 before extension.
    assign ld_shift = ld_raw_i >> {off_i, 3'b000};
    assign ld_byte  = ld_shift[7:0];
    assign ld_half  = ld_shift[15:0];

    always_comb begin
        wstrb_o   = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = ld_raw_i;
        case (size_i)
            SIZE_BYTE: begin
                wstrb_o   = 4'b0001 << off_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = sign_ext_i ? 32'(ld_byte) : {24'h0, ld_byte};
            end
            SIZE_HALF: begin
                wstrb_o   = 4'b0011 << off_i;
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = sign_ext_i ? 32'(ld_half) : {16'h0, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_axi_master.sv
// CPU data-memory AXI4-Lite initiator: one load or store in flight, CPU stalls
// on cpu_busy and sees a single cpu_done pulse per access.
module dmem_axi_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_byte_size,
    input  logic              cpu_sign_ext,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]  la_size;
    logic [1:0]  la_off;
    logic [3:0]  la_wstrb;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;
    logic        aw_hs;
    logic        w_hs;

    // In IDLE the aligner sees the incoming request; afterwards the latched one.
    assign la_size = (state_q == ST_IDLE) ? cpu_byte_size : size_q;
    assign la_off  = (state_q == ST_IDLE) ? cpu_addr[1:0] : addr_q[1:0];

    lsu_lane_align u_lane_align (
        .size_i     (la_size),
        .off_i      (la_off),
        .sign_ext_i (sext_q),
        .st_data_i  (cpu_wdata),
        .wstrb_o    (la_wstrb),
        .wdata_o    (la_wdata),
        .ld_raw_i   (M_AXI_RDATA),
        .ld_data_o  (la_rdata)
    );

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= SIZE_BYTE;
            sext_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        sext_d    = sext_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d    = cpu_addr;
                    size_d    = cpu_byte_size;
                    sext_d    = cpu_sign_ext;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    if (CHECK_ALIGN && is_misaligned(cpu_byte_size, cpu_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else if (cpu_we) begin
                        wdata_d = la_wdata;
                        wstrb_d = la_wstrb;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                // AW and W complete independently; either may finish first.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_d   = (M_AXI_BRESP != RESP_OKAY);
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                if (M_AXI_ARREADY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    err_d   = (M_AXI_RRESP != RESP_OKAY);
                    rdata_d = (M_AXI_RRESP != RESP_OKAY) ? 32'h0 : la_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        M_AXI_AWVALID = (state_q == ST_WR) && !aw_done_q;
        M_AXI_WVALID  = (state_q == ST_WR) && !w_done_q;
        M_AXI_BREADY  = (state_q == ST_WR_RESP);
        M_AXI_ARVALID = (state_q == ST_RD_ADDR);
        M_AXI_RREADY  = (state_q == ST_RD_DATA);
        cpu_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        cpu_done      = (state_q == ST_DONE);
        cpu_err       = (state_q == ST_DONE) && err_q;
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = PROT_DEFAULT;
    assign M_AXI_ARPROT = PROT_DEFAULT;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign cpu_rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_axi_master.sv
// Directed bench for dmem_axi_master with a negedge-driven AXI4-Lite slave model.
module tb_dmem_axi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_sign_ext;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_byte_size;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Per-transaction observations collected by run_xact
    int          r_done_cyc, r_done_cnt, r_aw_cycles;
    logic        r_any_axi, r_err, r_w_stable, r_hold_ok;
    logic [31:0] r_rdata, r_wdata, r_awaddr, r_araddr;
    logic [3:0]  r_strb;

    always #5 clk = ~clk;

    dmem_axi_master #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_byte_size (cpu_byte_size),
        .cpu_sign_ext  (cpu_sign_ext),
        .cpu_busy      (cpu_busy),
        .cpu_done      (cpu_done),
        .cpu_rdata     (cpu_rdata),
        .cpu_err       (cpu_err),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic slave_idle();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID  = 1'b0; M_AXI_BRESP  = 2'b00;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        M_AXI_RDATA   = 32'h0; M_AXI_RRESP = 2'b00;
    endtask

    // One CPU access. Cycle 1 is the IDLE cycle in which cpu_req is presented.
    task automatic run_xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input logic sext,
                            input int aw_lat, input int w_lat, input int r_lat,
                            input logic [1:0] resp, input logic [31:0] rd);
        int  n, aw_wait, w_wait, r_wait;
        bit  seen_w;
        n = 1; aw_wait = 0; w_wait = 0; r_wait = 0; seen_w = 0;
        r_done_cyc = 0; r_done_cnt = 0; r_aw_cycles = 0; r_any_axi = 1'b0;
        r_err = 1'b0; r_w_stable = 1'b1; r_hold_ok = 1'b1;
        r_rdata = 32'h0; r_wdata = 32'h0; r_strb = 4'h0; r_awaddr = 32'h0; r_araddr = 32'h0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        cpu_byte_size = size; cpu_sign_ext = sext;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            n++;
            if (M_AXI_AWVALID || M_AXI_ARVALID) r_any_axi = 1'b1;
            if (M_AXI_AWVALID) begin
                r_aw_cycles++;
                r_awaddr = M_AXI_AWADDR;
                M_AXI_AWREADY = (aw_wait == aw_lat);
                if (!M_AXI_AWREADY) aw_wait++;
            end else M_AXI_AWREADY = 1'b0;
            if (M_AXI_WVALID) begin
                if (!seen_w) begin
                    r_strb = M_AXI_WSTRB; r_wdata = M_AXI_WDATA; seen_w = 1;
                end else if (M_AXI_WSTRB !== r_strb || M_AXI_WDATA !== r_wdata) begin
                    r_w_stable = 1'b0;
                end
                M_AXI_WREADY = (w_wait == w_lat);
                if (!M_AXI_WREADY) w_wait++;
            end else M_AXI_WREADY = 1'b0;
            M_AXI_BVALID = M_AXI_BREADY;
            M_AXI_BRESP  = M_AXI_BREADY ? resp : 2'b00;
            if (M_AXI_ARVALID) r_araddr = M_AXI_ARADDR;
            M_AXI_ARREADY = M_AXI_ARVALID;
            if (M_AXI_RREADY) begin
                M_AXI_RVALID = (r_wait == r_lat);
                if (!M_AXI_RVALID) r_wait++;
            end else M_AXI_RVALID = 1'b0;
            M_AXI_RDATA = M_AXI_RVALID ? rd : 32'h0;
            M_AXI_RRESP = M_AXI_RVALID ? resp : 2'b00;
            if (cpu_done) begin
                r_done_cnt++;
                if (r_done_cnt == 1) begin
                    r_done_cyc = n; r_rdata = cpu_rdata; r_err = cpu_err;
                end
                cpu_req = 1'b0;
            end
            if (r_done_cnt > 0 && n == r_done_cyc + 2 && cpu_rdata !== r_rdata) r_hold_ok = 1'b0;
            if (r_done_cnt > 0 && n >= r_done_cyc + 3) break;
        end
        cpu_req = 1'b0;
    endtask

    int done_seen;

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_byte_size = 2'b00; cpu_sign_ext = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);

        check("rst_ctrl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                               M_AXI_RREADY, cpu_busy, cpu_done, cpu_err}), 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_addr", M_AXI_AWADDR | M_AXI_ARADDR, 32'h0);
        check("rst_wdata", M_AXI_WDATA, 32'h0);
        check("rst_wstrb_prot", 32'({M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // sb 0x1003, zero-wait slave
        run_xact(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 0, 0, 0, 2'b00, 32'h0);
        check("sb_strb", 32'(r_strb), 32'h8);
        check("sb_wdata", r_wdata, 32'hABAB_ABAB);
        check("sb_awaddr", r_awaddr, 32'h0000_1003);
        check("sb_latency", 32'(r_done_cyc), 32'd4);
        check("sb_err", 32'(r_err), 32'h0);
        check("sb_rdata", r_rdata, 32'h0);

        // sh 0x1002, WREADY three cycles after AWREADY
        run_xact(1'b1, 32'h0000_1002, 32'h0000_1234, 2'b01, 1'b0, 0, 3, 0, 2'b00, 32'h0);
        check("sh_strb", 32'(r_strb), 32'hC);
        check("sh_wdata", r_wdata, 32'h1234_1234);
        check("sh_aw_cycles", 32'(r_aw_cycles), 32'd1);
        check("sh_w_stable", 32'(r_w_stable), 32'h1);
        check("sh_done_count", 32'(r_done_cnt), 32'd1);
        check("sh_latency", 32'(r_done_cyc), 32'd7);

        // sw 0x2000, W accepted before AW
        run_xact(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 2'b10, 1'b0, 2, 0, 0, 2'b00, 32'h0);
        check("sw_strb", 32'(r_strb), 32'hF);
        check("sw_wdata", r_wdata, 32'hCAFE_F00D);
        check("sw_aw_cycles", 32'(r_aw_cycles), 32'd3);
        check("sw_latency", 32'(r_done_cyc), 32'd6);

        // lh 0x1002 sign-extended, RVALID five cycles late
        run_xact(1'b0, 32'h0000_1002, 32'h0, 2'b01, 1'b1, 0, 0, 5, 2'b00, 32'h8001_5A5A);
        check("lh_rdata", r_rdata, 32'hFFFF_8001);
        check("lh_araddr", r_araddr, 32'h0000_1002);
        check("lh_latency", 32'(r_done_cyc), 32'd9);
        check("lh_any_axi", 32'(r_any_axi), 32'h1);

        run_xact(1'b0, 32'h0000_1002, 32'h0, 2'b01, 1'b0, 0, 0, 5, 2'b00, 32'h8001_5A5A);
        check("lhu_rdata", r_rdata, 32'h0000_8001);

        run_xact(1'b0, 32'h0000_1001, 32'h0, 2'b00, 1'b0, 0, 0, 0, 2'b00, 32'h0000_F000);
        check("lbu_rdata", r_rdata, 32'h0000_00F0);
        check("lbu_latency", 32'(r_done_cyc), 32'd4);

        run_xact(1'b0, 32'h0000_1000, 32'h0, 2'b00, 1'b1, 0, 0, 0, 2'b00, 32'h0000_0080);
        check("lb_rdata", r_rdata, 32'hFFFF_FF80);

        run_xact(1'b0, 32'h0000_1000, 32'h0, 2'b10, 1'b0, 0, 0, 1, 2'b00, 32'hDEAD_BEEF);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw_hold", 32'(r_hold_ok), 32'h1);
        check("lw_hold_val", cpu_rdata, 32'hDEAD_BEEF);

        // misaligned word load is rejected locally
        run_xact(1'b0, 32'h0000_1002, 32'h0, 2'b10, 1'b0, 0, 0, 0, 2'b00, 32'h1111_1111);
        check("mis_any_axi", 32'(r_any_axi), 32'h0);
        check("mis_latency", 32'(r_done_cyc), 32'd2);
        check("mis_err", 32'(r_err), 32'h1);
        check("mis_rdata", r_rdata, 32'h0);

        // error responses
        run_xact(1'b1, 32'h0000_1000, 32'h0000_0055, 2'b00, 1'b0, 0, 0, 0, 2'b10, 32'h0);
        check("sb_slverr_err", 32'(r_err), 32'h1);
        check("sb_slverr_latency", 32'(r_done_cyc), 32'd4);
        run_xact(1'b0, 32'h0000_1004, 32'h0, 2'b10, 1'b0, 0, 0, 0, 2'b11, 32'h7777_7777);
        check("lw_decerr_err", 32'(r_err), 32'h1);
        check("lw_decerr_rdata", r_rdata, 32'h0);

        // reset while waiting for R
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000;
        cpu_byte_size = 2'b10; cpu_sign_ext = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            M_AXI_ARREADY = M_AXI_ARVALID;
            if (M_AXI_RREADY) break;
        end
        check("rstmid_in_rd_data", 32'(M_AXI_RREADY), 32'h1);
        rst_n = 1'b0; cpu_req = 1'b0;
        slave_idle();
        #1;
        check("rstmid_ctrl", 32'({M_AXI_ARVALID, M_AXI_RREADY, cpu_busy}), 32'h0);
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cpu_done) done_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (cpu_done) done_seen++;
        check("rstmid_no_done", 32'(done_seen), 32'd0);

        run_xact(1'b0, 32'h0000_3000, 32'h0, 2'b10, 1'b0, 0, 0, 0, 2'b00, 32'h0BAD_F00D);
        check("post_rst_rdata", r_rdata, 32'h0BAD_F00D);
        check("post_rst_latency", 32'(r_done_cyc), 32'd4);
        check("post_rst_done_count", 32'(r_done_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_axi_master.md
Name: dmem_axi_master

Overview:
CPU-side AXI4-Lite initiator for data memory: converts one CPU load/store request at a time into AXI4-Lite read or write transactions.
Generates WSTRB and lane-shifted WDATA from size and address on stores; extracts, lane-aligns and sign/zero-extends RDATA on loads.
Sits between the MEM pipeline stage and the interconnect / data-memory AXI slave; the CPU stalls while the block is busy.

Parameters:
ADDR_W, 32, AXI address width (data width fixed at 32)
CHECK_ALIGN, 1, 1 = misaligned accesses are rejected locally with error; 0 = passed through (strobes as computed, low bits ignored)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; sampled only in IDLE
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
cpu_byte_size  in  2  00 byte, 01 halfword, 10 word (11 treated as word)
cpu_sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend
cpu_busy  out  1  request in flight; CPU must hold the pipeline
cpu_done  out  1  one-cycle pulse: access complete
cpu_rdata  out  32  load result, valid while cpu_done=1
cpu_err  out  1  with cpu_done: SLVERR/DECERR received or misaligned
M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_W/3/1  write address channel
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2 ; M_AXI_BVALID  in  1 ; M_AXI_BREADY  out  1
M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_W/3/1 ; M_AXI_ARREADY  in  1
M_AXI_RDATA  in  32 ; M_AXI_RRESP  in  2 ; M_AXI_RVALID  in  1 ; M_AXI_RREADY  out  1

Behaviour:
- Reset (async, rst_n=0): state IDLE; all VALIDs, BREADY, RREADY, cpu_busy, cpu_done and cpu_err are 0; cpu_rdata, AWADDR, ARADDR, WDATA are 0; WSTRB is 0; PROT is 3'b000.
- Reset mid-transaction: the transaction is abandoned and no cpu_done is issued.
- FSM states: IDLE, WR (AW/W pending), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - cpu_req=1 latches all cpu_* inputs and sets cpu_busy=1 from the next edge.
  - Store goes to WR with AWVALID=WVALID=1.
  - Load goes to RD_ADDR with ARVALID=1.
  - Misaligned access (CHECK_ALIGN=1: half with addr[0]=1, word with addr[1:0]!=0) goes directly to DONE with err=1; no AXI traffic.
- WR:
  - AWVALID drops the cycle after AW handshake (AWVALID&AWREADY).
  - WVALID drops the cycle after W handshake; the two handshakes complete independently, in either order or in the same cycle.
  - Address, data and strobe are held stable while their VALID is high.
  - When both handshakes are done, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID, go to DONE; err = (BRESP!=00).
- RD_ADDR: on ARREADY, deassert ARVALID, assert RREADY, go to RD_DATA.
- RD_DATA: on RVALID, capture the extended result into cpu_rdata, drop RREADY, go to DONE; err = (RRESP!=00).
- DONE: cpu_done=1 and cpu_busy=0 for exactly one cycle, then IDLE. A new cpu_req is accepted in the following IDLE cycle at the earliest.
- Minimum latency, zero-wait slave (req edge to cpu_done): store 4 cycles (IDLE→WR→WR_RESP→DONE, B same cycle); load 4 cycles.
- Store strobes (off = addr[1:0]):
  - Byte: WSTRB = 4'b0001<<off; WDATA = {4{wdata[7:0]}}.
  - Half: WSTRB = 4'b0011<<off; WDATA = {2{wdata[15:0]}}.
  - Word: WSTRB = 4'b1111; WDATA = wdata.
- Load extraction:
  - Byte: RDATA[8*off+:8] extended to 32 bits.
  - Half: RDATA[8*off+:16] extended to 32 bits.
  - Word: RDATA unchanged.
- AWADDR/ARADDR carry the full unmodified cpu_addr.
- cpu_rdata holds its last value outside cpu_done. On stores and errors it is 0.
- cpu_req while busy is ignored; the CPU holds it stable until cpu_done.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR, SIZE_BYTE/HALF/WORD, PROT_DEFAULT.
- One combinational sub-module, lsu_lane_align, handles strobe and WDATA replication on stores and extraction with sign/zero extension on loads; it is reusable by the instruction-fetch master.
- The FSM stays in dmem_axi_master.

Test Plan:
- sb addr 0x1003 wdata 0x000000AB, slave AWREADY/WREADY immediate → WSTRB=4'b1000, WDATA=0xABABABAB, cpu_done after 4 cycles, err=0.
- sh addr 0x1002 wdata 0x1234, WREADY 3 cycles after AWREADY → AWVALID drops after 1 cycle, WVALID held with stable data until WREADY, WSTRB=4'b1100, single cpu_done.
- lh addr 0x1002 sign_ext=1, RDATA=0x8001_5A5A, RVALID delayed 5 cycles → cpu_rdata=0xFFFF8001; same access with sign_ext=0 → 0x00008001.
- lbu addr 0x1001, RDATA=0x0000_F000 → cpu_rdata=0x000000F0; lw addr 0x1000 → RDATA passed through unchanged.
- lw addr 0x1002 (CHECK_ALIGN=1) → no AWVALID/ARVALID ever asserted, cpu_done with cpu_err=1 after 2 cycles; store with BRESP=2'b10 → cpu_err=1.
- rst_n low while in RD_DATA → ARVALID/RREADY/cpu_busy immediately 0, no cpu_done; next request after reset completes normally.
